// File: rtl/dilithium_op_sequencer.sv
// dilithium_op_sequencer
//   Issues the full opcode sequence (keygen, verify or sign) to the Dilithium
//   core's 4-bit op/ready port from a single start/mode request. Each opcode is
//   held on op_o/op_valid_o until the core accepts it. After an accept, a guard
//   window masks the core's ready line. The sequencer then waits for the core to
//   become ready again before it issues the next opcode. Each wait on a single
//   opcode is bounded by a timeout, abort cancels a run, and a saturating counter
//   records how long the run took.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         run request, sampled only while idle
//   mode_i  [1:0]   0=keygen, 1=verify, 2=sign, 3=illegal
//   abort_i         cancel the current run (ignored while idle)
//   op_o    [OP_W]  opcode to the core
//   op_valid_o      opcode valid
//   op_ready_i      core idle and able to accept an opcode
//   busy_o          run in progress
//   step_o  [1:0]   index of the opcode currently issued or awaited
//   done_o          1-cycle pulse on run completion
//   err_o           1-cycle pulse on error
//   err_code_o[1:0] 0=none, 1=illegal mode, 2=timeout, 3=aborted
//   cycles_o[CNT_W] start-acceptance cycle through done cycle, saturating
module dilithium_op_sequencer #(
  parameter int OP_W           = 4,
  parameter int GUARD_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic             abort_i,
  output logic [OP_W-1:0]  op_o,
  output logic             op_valid_o,
  input  logic             op_ready_i,
  output logic             busy_o,
  output logic [1:0]       step_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [CNT_W-1:0] cycles_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, FINISH} state_t;

  // The guard counter runs 0..GUARD_CYCLES-1.
  // The wait counter runs 0..TIMEOUT_CYCLES-1.
  localparam int            GW     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit            T_EN   = (TIMEOUT_CYCLES != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [OP_W-1:0] op_lookup(input logic [1:0] mode,
                                                input logic [1:0] idx);
    logic [3:0] code;
    code = 4'b0000;
    case ({mode, idx})
      4'b00_00: code = 4'b1111;  // keygen: STOR_SEED
      4'b00_01: code = 4'b0111;  //         KGEN
      4'b00_10: code = 4'b1001;  //         LOAD_SK
      4'b00_11: code = 4'b1000;  //         LOAD_PK
      4'b01_00: code = 4'b1100;  // verify: STOR_PK
      4'b01_01: code = 4'b1110;  //         STOR_SIG
      4'b01_10: code = 4'b0001;  //         DIGEST_MSG
      4'b01_11: code = 4'b0100;  //         VRFY
      4'b10_00: code = 4'b1101;  // sign:   STOR_SK
      4'b10_01: code = 4'b0001;  //         DIGEST_MSG
      4'b10_10: code = 4'b0010;  //         SIGN
      4'b10_11: code = 4'b1010;  //         LOAD_SIG
      default:  code = 4'b0000;
    endcase
    return OP_W'(code);
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [TW-1:0]     wcnt_q, wcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [OP_W-1:0]   op_d;
  logic              op_valid_d, busy_d, done_d, err_d;
  logic [1:0]        step_d, err_code_d;
  logic [CNT_W-1:0]  cycles_d;
  logic              in_wait_state;
  logic              timeout_hit;

  // The wait counter runs only in states that depend on the core's ready line.
  assign in_wait_state = (state_q == ISSUE) || (state_q == WAIT) || (state_q == FINISH);
  assign timeout_hit   = T_EN && in_wait_state && (wcnt_q == T_LAST);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    step_d     = step_o;
    op_d       = op_o;
    op_valid_d = op_valid_o;
    busy_d     = busy_o;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_o;
    cycles_d   = cycles_o;
    run_cnt_d  = run_cnt_q;
    wcnt_d     = wcnt_q;
    gcnt_d     = gcnt_q;

    if (state_q != IDLE) run_cnt_d = sat_inc(run_cnt_q);
    if (in_wait_state)   wcnt_d    = wcnt_q + TW'(1);

    if (state_q == IDLE) begin
      if (start_i) begin
        if (mode_i == 2'd3) begin
          err_d      = 1'b1;
          err_code_d = 2'd1;
        end else begin
          mode_d     = mode_i;
          step_d     = 2'd0;
          op_d       = op_lookup(mode_i, 2'd0);
          op_valid_d = 1'b1;
          busy_d     = 1'b1;
          err_code_d = 2'd0;
          cycles_d   = '0;
          // The start-acceptance cycle is the first cycle counted.
          run_cnt_d  = CNT_W'(1);
          wcnt_d     = '0;
          state_d    = ISSUE;
        end
      end
    end else if (abort_i || timeout_hit) begin
      // Abort outranks timeout. Both outrank any accept or ready in this cycle.
      state_d    = IDLE;
      op_valid_d = 1'b0;
      busy_d     = 1'b0;
      step_d     = 2'd0;
      err_d      = 1'b1;
      err_code_d = abort_i ? 2'd3 : 2'd2;
    end else begin
      case (state_q)
        ISSUE: begin
          if (op_ready_i) begin
            op_valid_d = 1'b0;
            gcnt_d     = '0;
            state_d    = GUARD;
          end
        end
        GUARD: begin
          // The core may still show ready from before it took the opcode.
          if (gcnt_q == G_LAST) begin
            wcnt_d  = '0;
            state_d = (step_o == 2'd3) ? FINISH : WAIT;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
        WAIT: begin
          if (op_ready_i) begin
            step_d     = step_o + 2'd1;
            op_d       = op_lookup(mode_q, step_o + 2'd1);
            op_valid_d = 1'b1;
            wcnt_d     = '0;
            state_d    = ISSUE;
          end
        end
        FINISH: begin
          if (op_ready_i) begin
            done_d   = 1'b1;
            cycles_d = sat_inc(run_cnt_q);
            busy_d   = 1'b0;
            step_d   = 2'd0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_o       <= '0;
      op_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      step_o     <= 2'd0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      cycles_o   <= '0;
    end else begin
      state_q    <= state_d;
      op_o       <= op_d;
      op_valid_o <= op_valid_d;
      busy_o     <= busy_d;
      step_o     <= step_d;
      done_o     <= done_d;
      err_o      <= err_d;
      err_code_o <= err_code_d;
      cycles_o   <= cycles_d;
    end
  end

  // Working registers are always reinitialised before use, so they carry no reset.
  always_ff @(posedge clk) begin
    mode_q    <= mode_d;
    run_cnt_q <= run_cnt_d;
    wcnt_q    <= wcnt_d;
    gcnt_q    <= gcnt_d;
  end

endmodule

// File: tb/tb_dilithium_op_sequencer.sv
// tb_dilithium_op_sequencer
//   Directed bench for dilithium_op_sequencer (GUARD_CYCLES=1, TIMEOUT_CYCLES=10).
//   A small in-bench core model drives op_ready_i for each scenario.
module tb_dilithium_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        abort_i;
  logic [3:0]  op_o;
  logic        op_valid_o;
  logic        op_ready_i;
  logic        busy_o;
  logic [1:0]  step_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [31:0] cycles_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] kg_exp [4] = '{4'b1111, 4'b0111, 4'b1001, 4'b1000};
  logic [3:0] sg_exp [4] = '{4'b1101, 4'b0001, 4'b0010, 4'b1010};
  logic [3:0] seen   [4];
  int vcount, dcount, dcyc, ecount, ecyc, nacc, holdcyc, holdbad, lowcnt, acyc;
  bit cut, found;

  dilithium_op_sequencer #(
    .OP_W(4), .GUARD_CYCLES(1), .TIMEOUT_CYCLES(10), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .abort_i(abort_i),
    .op_o(op_o), .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .busy_o(busy_o), .step_o(step_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    start_i = 1'b1;
    mode_i  = m;
    tick();
    start_i = 1'b0;
  endtask

  // Observes ncyc cycles with op_ready_i left as is, starting with the current one.
  task automatic run_loop(input int ncyc);
    vcount = 0; dcount = 0; dcyc = 0; ecount = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (op_valid_o) begin
        if (vcount < 4) seen[vcount] = op_o;
        vcount++;
      end
      if (done_o) begin dcount++; dcyc = c; end
      if (err_o) ecount++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; mode_i = 2'd0; abort_i = 1'b0; op_ready_i = 1'b0;
    tick(); tick();
    check("rst_op", op_o, 0);
    check("rst_valid", op_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_step", step_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_code", err_code_o, 0);
    check("rst_cycles", cycles_o, 0);
    rst = 1'b0;
    tick();

    // Keygen with ready tied high: 3 cycles per opcode, so done_o is seen in cycle 13.
    op_ready_i = 1'b1;
    do_start(2'd0);
    check("kg_valid_first", op_valid_o, 1);
    check("kg_busy", busy_o, 1);
    run_loop(20);
    for (int i = 0; i < 4; i++) check($sformatf("kg_op%0d", i), seen[i], kg_exp[i]);
    check("kg_valid_cycles", vcount, 4);
    check("kg_done_count", dcount, 1);
    check("kg_done_cycle", dcyc, 13);
    check("kg_cycles_meas", cycles_o, dcyc);
    check("kg_busy_end", busy_o, 0);

    // Sign: ready low for the first 3 cycles, then low for 5 cycles after each accept.
    // Accepts happen in cycles 4, 11, 18 and 25, and done_o is seen in cycle 32.
    op_ready_i = 1'b0; lowcnt = 3; nacc = 0; holdcyc = 0; holdbad = 0; dcount = 0; dcyc = 0;
    do_start(2'd2);
    for (int c = 1; c <= 45; c++) begin
      op_ready_i = (lowcnt == 0);
      if (op_valid_o && op_ready_i) begin
        if (nacc < 4) seen[nacc] = op_o;
        nacc++;
        lowcnt = 5;
      end else begin
        if (op_valid_o) begin
          holdcyc++;
          if (nacc > 3 || op_o != sg_exp[nacc]) holdbad++;
        end
        if (lowcnt > 0) lowcnt--;
      end
      if (done_o) begin dcount++; dcyc = c; end
      tick();
    end
    for (int i = 0; i < 4; i++) check($sformatf("sg_op%0d", i), seen[i], sg_exp[i]);
    check("sg_accepts", nacc, 4);
    check("sg_hold_cycles", holdcyc, 3);
    check("sg_hold_stable", holdbad, 0);
    check("sg_done_count", dcount, 1);
    check("sg_done_cycle", dcyc, 32);
    check("sg_cycles", cycles_o, 32);

    // Verify: the core stops driving ready after it accepts 1110 in cycle 4.
    // WAIT is entered at the end of cycle 5, and err_o is seen 10 edges later, in cycle 16.
    op_ready_i = 1'b1; cut = 1'b0; acyc = 0; ecount = 0; ecyc = 0; dcount = 0;
    do_start(2'd1);
    for (int c = 1; c <= 30; c++) begin
      op_ready_i = !cut;
      if (op_valid_o && op_ready_i && op_o == 4'b1110) begin cut = 1'b1; acyc = c; end
      if (err_o) begin ecount++; ecyc = c; end
      if (done_o) dcount++;
      tick();
    end
    check("to_accept_cycle", acyc, 4);
    check("to_err_cycle", ecyc, 16);
    check("to_err_count", ecount, 1);
    check("to_no_done", dcount, 0);
    check("to_code", err_code_o, 2);
    check("to_busy", busy_o, 0);
    check("to_valid", op_valid_o, 0);

    // Illegal mode, then a normal keygen run.
    op_ready_i = 1'b1;
    do_start(2'd3);
    check("ill_err", err_o, 1);
    check("ill_code", err_code_o, 1);
    check("ill_valid", op_valid_o, 0);
    check("ill_busy", busy_o, 0);
    run_loop(6);
    check("ill_never_valid", vcount, 0);
    check("ill_err_once", ecount, 1);
    do_start(2'd0);
    check("ill_next_code", err_code_o, 0);
    check("ill_next_valid", op_valid_o, 1);
    check("ill_next_op", op_o, 4'b1111);
    run_loop(20);
    check("ill_next_done", dcount, 1);
    check("ill_next_ops", vcount, 4);

    // Abort during step 2 of sign. The accept in that same cycle is lost.
    op_ready_i = 1'b1; found = 1'b0;
    do_start(2'd2);
    for (int c = 1; c <= 40; c++) begin
      if (op_valid_o && step_o == 2'd2) begin found = 1'b1; break; end
      tick();
    end
    check("ab_reached_step2", found, 1);
    check("ab_step2_op", op_o, 4'b0010);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("ab_valid", op_valid_o, 0);
    check("ab_err", err_o, 1);
    check("ab_code", err_code_o, 3);
    check("ab_step", step_o, 0);
    check("ab_busy", busy_o, 0);
    tick();
    check("ab_err_pulse", err_o, 0);
    do_start(2'd0);
    check("ab_restart_valid", op_valid_o, 1);
    check("ab_restart_busy", busy_o, 1);
    run_loop(20);
    check("ab_restart_done", dcount, 1);

    // Reset asserted in the middle of a verify run (cycle 5, step 1 GUARD).
    op_ready_i = 1'b1;
    do_start(2'd1);
    tick(); tick(); tick(); tick();
    check("mr_pre_busy", busy_o, 1);
    check("mr_pre_step", step_o, 1);
    rst = 1'b1;
    tick();
    check("mr_op", op_o, 0);
    check("mr_valid", op_valid_o, 0);
    check("mr_busy", busy_o, 0);
    check("mr_step", step_o, 0);
    check("mr_done", done_o, 0);
    check("mr_err", err_o, 0);
    check("mr_code", err_code_o, 0);
    check("mr_cycles", cycles_o, 0);
    tick();
    check("mr_no_pulse", {30'd0, done_o, err_o}, 0);
    rst = 1'b0;
    do_start(2'd1);
    check("mr_new_step", step_o, 0);
    check("mr_new_op", op_o, 4'b1100);
    check("mr_new_valid", op_valid_o, 1);
    run_loop(20);
    check("mr_new_done", dcount, 1);
    check("mr_new_cycles", cycles_o, 13);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dilithium_op_sequencer.md
Name: dilithium_op_sequencer

Overview:
- Drives the low-resource Dilithium core's 4-bit opcode port from a single start/mode request.
- Issues the full opcode sequence for keygen, sign or verify, one opcode per core-ready handshake.
- Adds a ready guard window, a per-operation timeout with error reporting, abort, and a run cycle counter.
- Sits between the top-level controller and the core's op/ready interface.

Parameters:
- OP_W, 4, opcode width. Upper 2 bits are the class, lower 2 bits the payload type.
- GUARD_CYCLES, 1, cycles after each accept during which op_ready_i is ignored (>=1).
- TIMEOUT_CYCLES, 65535, max cycles spent waiting on a single opcode. 0 disables the timeout.
- CNT_W, 32, width of the run cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  request a run. Sampled only in IDLE.
- mode_i  in  2  0=keygen, 1=verify, 2=sign, 3=illegal
- abort_i  in  1  cancel the current run
- op_o  out  OP_W  opcode to the core
- op_valid_o  out  1  opcode valid
- op_ready_i  in  1  core idle and able to accept an opcode
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE
- step_o  out  2  index of the opcode currently issued or awaited
- done_o  out  1  1-cycle pulse when a run completes
- err_o  out  1  1-cycle pulse on error
- err_code_o  out  2  0=none, 1=illegal mode, 2=timeout, 3=aborted. Held until the next start.
- cycles_o  out  CNT_W  cycles from start acceptance to done. Saturating. Held until the next start.

Behaviour:
- All outputs are registered. Reset values: op_o=0, op_valid_o=0, busy_o=0, step_o=0, done_o=0, err_o=0, err_code_o=0, cycles_o=0. FSM returns to IDLE.
- Opcode sequences, step 0..3:
  - keygen: 1111 STOR_SEED, 0111 KGEN, 1001 LOAD_SK, 1000 LOAD_PK.
  - verify: 1100 STOR_PK, 1110 STOR_SIG, 0001 DIGEST_MSG, 0100 VRFY.
  - sign: 1101 STOR_SK, 0001 DIGEST_MSG, 0010 SIGN, 1010 LOAD_SIG.
- States: IDLE, ISSUE, GUARD, WAIT, FINISH.
- IDLE, start_i=1, legal mode:
  - latch the mode; step=0; clear cycles_o and err_code_o; go to ISSUE.
  - op_valid_o is asserted the next cycle (1-cycle start latency).
- IDLE, start_i=1, mode_i=3: err_o pulses the next cycle, err_code_o=1, stay in IDLE.
- ISSUE:
  - op_valid_o=1 with op_o = table[mode][step], held stable until op_valid_o & op_ready_i.
  - On accept, op_valid_o deasserts the next cycle and the FSM goes to GUARD.
- GUARD: waits GUARD_CYCLES cycles, op_ready_i ignored. Then go to WAIT if step<3, otherwise to FINISH.
- WAIT: on op_ready_i=1, step increments and the FSM goes to ISSUE. The next op_valid_o rises 1 cycle after ready is seen.
- FINISH: on op_ready_i=1, done_o pulses, cycles_o is latched, busy_o drops, go to IDLE.
- Timeout:
  - The wait counter clears on entering ISSUE or WAIT/FINISH and counts every cycle in those states.
  - When it reaches TIMEOUT_CYCLES (nonzero): op_valid_o drops, err_o pulses, err_code_o=2, go to IDLE.
- abort_i in any non-IDLE state: op_valid_o drops the next cycle, err_o pulses, err_code_o=3, go to IDLE. abort_i in IDLE is ignored.
- Simultaneous events:
  - abort_i wins over timeout, and timeout wins over accept/ready in the same cycle.
  - An accept in the same cycle as abort is still lost from the sequencer's view.
- start_i while busy is ignored.
- Cycle counter: increments every cycle while busy and saturates at all-ones. It counts the start-acceptance cycle through the done cycle inclusive.
- rst mid-run: everything returns to reset values on the next edge. No done or err pulse is generated.

Test Plan:
- Keygen, op_ready_i tied 1, GUARD_CYCLES=1:
  - op_o sequence is 1111, 0111, 1001, 1000, each with a 1-cycle op_valid_o.
  - done_o pulses exactly once and cycles_o equals the measured start-to-done count.
- Sign with the core holding ready low for 5 cycles after each accept:
  - opcodes 1101, 0001, 0010, 1010 in order, none reissued.
  - op_valid_o stays held while op_ready_i=0 in ISSUE.
- Verify, TIMEOUT_CYCLES=10, core never reasserts ready after 1110:
  - err_o pulses 10 cycles after entering WAIT, err_code_o=2, busy_o=0, no done_o.
- start_i with mode_i=3:
  - err_o pulses next cycle, err_code_o=1, op_valid_o never rises.
  - A following keygen start runs normally and clears err_code_o to 0.
- abort_i asserted at step 2 of sign:
  - op_valid_o=0 the next cycle, err_code_o=3, step_o=0, a subsequent start accepted.
- rst asserted mid-verify, then a new start:
  - all outputs take reset values, no pulses, and the new run begins at step 0.
